// File: rtl/axi_bus_sequencer_if.sv
// AXI4-Lite master-side bundle for the CPU bus sequencer.
// Master drives requests and ready; slave drives responses.
interface axi_bus_sequencer_if;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  modport master (
    output m_awaddr, m_awprot, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready,
    output m_araddr, m_arprot, m_arvalid,
    input  m_arready,
    input  m_rdata, m_rresp, m_rvalid,
    output m_rready
  );

  modport slave (
    input  m_awaddr, m_awprot, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready,
    input  m_araddr, m_arprot, m_arvalid,
    output m_arready,
    output m_rdata, m_rresp, m_rvalid,
    input  m_rready
  );
endinterface

// File: rtl/axi_bus_sequencer.sv
// Turns one classified CPU bus cycle into an AXI4-Lite
// transaction or a one-cycle internal strobe, with timeout.
module axi_bus_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  addr_type,
  input  logic [31:0] A32,
  input  logic [31:0] D32,
  input  logic [3:0]  wstrb,
  input  logic        is_read,
  output logic        cpu_ready,
  output logic [7:0]  cpu_rdata,
  output logic        int_sel,
  output logic [2:0]  int_type,
  output logic [11:0] int_addr,
  output logic [7:0]  int_wdata,
  output logic        int_we,
  input  logic [7:0]  int_rdata,
  output logic        bus_err,
  axi_bus_sequencer_if.master m
);

  localparam logic [2:0] AT_NOP = 3'd0;
  localparam logic [2:0] AT_AXI = 3'd2;
  localparam logic [2:0] AT_ROM = 3'd3;
  localparam logic [2:0] AT_RAM = 3'd4;
  localparam logic [2:0] AT_PER = 3'd5;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INT, S_INT_RD, S_AR,
    S_R, S_AWW, S_B, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  lane_q, lane_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        int_sel_q, int_sel_d;
  logic [2:0]  int_type_q, int_type_d;
  logic [11:0] int_addr_q, int_addr_d;
  logic [7:0]  int_wdata_q, int_wdata_d;
  logic        int_we_q, int_we_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic        awvalid_q, awvalid_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic [31:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;

  logic is_axi, is_int, tmo;
  logic aw_ok, w_ok;
  logic fin, fin_err, fin_ff;

  assign is_axi = (addr_type == AT_AXI);
  assign is_int = (addr_type == AT_ROM) ||
                  (addr_type == AT_RAM) ||
                  (addr_type == AT_PER);
  assign tmo    = (cnt_q == TO_LAST);
  assign aw_ok  = !awvalid_q || m.m_awready;
  assign w_ok   = !wvalid_q || m.m_wready;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    cpu_ready_d = cpu_ready_q;
    cpu_rdata_d = cpu_rdata_q;
    int_sel_d   = 1'b0;
    int_type_d  = int_type_q;
    int_addr_d  = int_addr_q;
    int_wdata_d = int_wdata_q;
    int_we_d    = int_we_q;
    bus_err_d   = 1'b0;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    fin         = 1'b0;
    fin_err     = 1'b0;
    fin_ff      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (addr_type != AT_NOP) begin
          cnt_d  = '0;
          lane_d = A32[1:0];
          unique case (1'b1)
            is_axi && is_read: begin
              state_d   = S_AR;
              araddr_d  = A32;
              arvalid_d = 1'b1;
            end
            is_axi && !is_read: begin
              state_d   = S_AWW;
              awaddr_d  = A32;
              wdata_d   = D32;
              wstrb_d   = wstrb;
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
            end
            is_int: begin
              state_d     = S_INT;
              int_sel_d   = 1'b1;
              int_type_d  = addr_type;
              int_addr_d  = A32[11:0];
              int_wdata_d = D32[7:0];
              int_we_d    = !is_read;
            end
            default: begin
              fin     = 1'b1;
              fin_err = 1'b1;
              fin_ff  = 1'b1;
            end
          endcase
        end
      end
      S_INT: begin
        if (int_we_q) fin = 1'b1;
        else state_d = S_INT_RD;
      end
      S_INT_RD: begin
        cpu_rdata_d = int_rdata;
        fin = 1'b1;
      end
      S_AR: begin
        cnt_d = cnt_q + 8'd1;
        if (tmo) begin
          arvalid_d = 1'b0;
          fin = 1'b1; fin_err = 1'b1; fin_ff = 1'b1;
        end else if (m.m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end
      end
      S_R: begin
        cnt_d = cnt_q + 8'd1;
        if (m.m_rvalid) begin
          rready_d = 1'b0;
          fin = 1'b1;
          if (m.m_rresp != 2'b00) begin
            fin_err = 1'b1;
            fin_ff  = 1'b1;
          end else begin
            cpu_rdata_d = m.m_rdata[{lane_q, 3'b000} +: 8];
          end
        end else if (tmo) begin
          rready_d = 1'b0;
          fin = 1'b1; fin_err = 1'b1; fin_ff = 1'b1;
        end
      end
      S_AWW: begin
        cnt_d = cnt_q + 8'd1;
        if (tmo) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          fin = 1'b1; fin_err = 1'b1; fin_ff = 1'b1;
        end else begin
          if (m.m_awready) awvalid_d = 1'b0;
          if (m.m_wready)  wvalid_d  = 1'b0;
          if (aw_ok && w_ok) begin
            bready_d = 1'b1;
            state_d  = S_B;
          end
        end
      end
      S_B: begin
        cnt_d = cnt_q + 8'd1;
        if (m.m_bvalid) begin
          bready_d = 1'b0;
          fin = 1'b1;
          fin_err = (m.m_bresp != 2'b00);
        end else if (tmo) begin
          bready_d = 1'b0;
          fin = 1'b1; fin_err = 1'b1; fin_ff = 1'b1;
        end
      end
      S_DONE: begin
        if (addr_type == AT_NOP) begin
          state_d     = S_IDLE;
          cpu_ready_d = 1'b0;
        end
      end
    endcase

    if (fin) begin
      state_d     = S_DONE;
      cpu_ready_d = 1'b1;
      bus_err_d   = fin_err;
      if (fin_ff) cpu_rdata_d = 8'hFF;
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lane_q      <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      int_sel_q   <= 1'b0;
      int_type_q  <= '0;
      int_addr_q  <= '0;
      int_wdata_q <= '0;
      int_we_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      int_sel_q   <= int_sel_d;
      int_type_q  <= int_type_d;
      int_addr_q  <= int_addr_d;
      int_wdata_q <= int_wdata_d;
      int_we_q    <= int_we_d;
      bus_err_q   <= bus_err_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
    end
  end

  assign cpu_ready   = cpu_ready_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign int_sel     = int_sel_q;
  assign int_type    = int_type_q;
  assign int_addr    = int_addr_q;
  assign int_wdata   = int_wdata_q;
  assign int_we      = int_we_q;
  assign bus_err     = bus_err_q;
  assign m.m_awaddr  = awaddr_q;
  assign m.m_awprot  = 3'b000;
  assign m.m_awvalid = awvalid_q;
  assign m.m_wdata   = wdata_q;
  assign m.m_wstrb   = wstrb_q;
  assign m.m_wvalid  = wvalid_q;
  assign m.m_bready  = bready_q;
  assign m.m_araddr  = araddr_q;
  assign m.m_arprot  = 3'b000;
  assign m.m_arvalid = arvalid_q;
  assign m.m_rready  = rready_q;

endmodule

// File: tb/tb_axi_bus_sequencer.sv
// Bench for axi_bus_sequencer: vector table, random cycles
// against a latency/response model, reset and timeout cases.
module tb_axi_bus_sequencer;

  localparam int TO = 8;
  localparam logic [2:0] AT_NOP = 3'd0;
  localparam logic [2:0] AT_UNK = 3'd1;
  localparam logic [2:0] AT_AXI = 3'd2;
  localparam logic [2:0] AT_ROM = 3'd3;
  localparam logic [2:0] AT_RAM = 3'd4;
  localparam logic [2:0] AT_PER = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  addr_type = AT_NOP;
  logic [31:0] A32 = '0;
  logic [31:0] D32 = '0;
  logic [3:0]  wstrb = '0;
  logic        is_read = 1'b0;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic        int_sel;
  logic [2:0]  int_type;
  logic [11:0] int_addr;
  logic [7:0]  int_wdata;
  logic        int_we;
  logic [7:0]  int_rdata;
  logic        bus_err;

  axi_bus_sequencer_if bus ();

  axi_bus_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_type(addr_type), .A32(A32), .D32(D32),
    .wstrb(wstrb), .is_read(is_read),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .int_sel(int_sel), .int_type(int_type),
    .int_addr(int_addr), .int_wdata(int_wdata),
    .int_we(int_we), .int_rdata(int_rdata),
    .bus_err(bus_err), .m(bus)
  );

  always #5 clk = ~clk;

  // slave configuration, written only by the stimulus process
  int          arl_v = 0, rl_v = 0, awl_v = 0, wl_v = 0, bl_v = 0;
  logic [31:0] rdata_v = '0;
  logic [1:0]  rresp_v = '0, bresp_v = '0;

  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
  int isel_n = 0, err_n = 0;
  logic [31:0] cap_araddr = '0, cap_awaddr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  logic [11:0] cap_iaddr = '0;
  logic [7:0]  cap_iwdata = '0;
  logic [2:0]  cap_itype = '0;
  logic        cap_iwe = 1'b0;

  logic [7:0] mem [0:4095];
  logic       wvld [0:4095];
  initial for (int i = 0; i < 4096; i++) wvld[i] = 1'b0;

  assign bus.m_arready = bus.m_arvalid && (ar_cnt >= arl_v);
  assign bus.m_rvalid  = bus.m_rready && (r_cnt >= rl_v);
  assign bus.m_rdata   = rdata_v;
  assign bus.m_rresp   = bus.m_rvalid ? rresp_v : 2'b00;
  assign bus.m_awready = bus.m_awvalid && (aw_cnt >= awl_v);
  assign bus.m_wready  = bus.m_wvalid && (w_cnt >= wl_v);
  assign bus.m_bvalid  = bus.m_bready && (b_cnt >= bl_v);
  assign bus.m_bresp   = bus.m_bvalid ? bresp_v : 2'b00;
  assign int_rdata = wvld[int_addr] ? mem[int_addr]
                                    : (int_addr[7:0] ^ 8'hA5);

  always @(posedge clk) begin
    ar_cnt <= (bus.m_arvalid && !bus.m_arready) ? ar_cnt + 1 : 0;
    r_cnt  <= (bus.m_rready && !bus.m_rvalid) ? r_cnt + 1 : 0;
    aw_cnt <= (bus.m_awvalid && !bus.m_awready) ? aw_cnt + 1 : 0;
    w_cnt  <= (bus.m_wvalid && !bus.m_wready) ? w_cnt + 1 : 0;
    b_cnt  <= (bus.m_bready && !bus.m_bvalid) ? b_cnt + 1 : 0;
    if (bus.m_arvalid && bus.m_arready) begin
      ar_hs <= ar_hs + 1; cap_araddr <= bus.m_araddr;
    end
    if (bus.m_rvalid && bus.m_rready) r_hs <= r_hs + 1;
    if (bus.m_awvalid && bus.m_awready) begin
      aw_hs <= aw_hs + 1; cap_awaddr <= bus.m_awaddr;
    end
    if (bus.m_wvalid && bus.m_wready) begin
      w_hs <= w_hs + 1;
      cap_wdata <= bus.m_wdata; cap_wstrb <= bus.m_wstrb;
    end
    if (bus.m_bvalid && bus.m_bready) b_hs <= b_hs + 1;
    if (bus_err) err_n <= err_n + 1;
    if (int_sel) begin
      isel_n <= isel_n + 1;
      cap_iaddr <= int_addr; cap_iwdata <= int_wdata;
      cap_itype <= int_type; cap_iwe <= int_we;
      if (int_we) begin
        mem[int_addr]  <= int_wdata;
        wvld[int_addr] <= 1'b1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  at;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  strb;
    logic        rd;
    int          arl, rl, awl, wl, bl;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    int          lat;
    logic [7:0]  rbyte;
    logic        err;
    logic        chkrd;
  } vec_t;

  function automatic vec_t mk(
    logic [2:0] at, logic [31:0] a, logic [31:0] d,
    logic [3:0] strb, logic rd,
    int arl, int rl, int awl, int wl, int bl,
    logic [31:0] rdata, logic [1:0] rresp, logic [1:0] bresp,
    int lat, logic [7:0] rbyte, logic err, logic chkrd);
    vec_t v;
    v.at = at; v.a = a; v.d = d; v.strb = strb; v.rd = rd;
    v.arl = arl; v.rl = rl; v.awl = awl; v.wl = wl; v.bl = bl;
    v.rdata = rdata; v.rresp = rresp; v.bresp = bresp;
    v.lat = lat; v.rbyte = rbyte; v.err = err; v.chkrd = chkrd;
    return v;
  endfunction

  function automatic logic [7:0] mem_exp(logic [11:0] a);
    return wvld[a] ? mem[a] : (a[7:0] ^ 8'hA5);
  endfunction

  function automatic logic is_int_t(logic [2:0] at);
    return at == AT_ROM || at == AT_RAM || at == AT_PER;
  endfunction

  // expected completion from phase lengths and response codes
  function automatic void model(inout vec_t v);
    int t;
    logic [31:0] sh;
    v.err = 1'b0; v.rbyte = 8'h00; v.chkrd = 1'b0;
    if (v.at == AT_AXI && v.rd) begin
      t = v.arl + v.rl + 2;
      v.chkrd = 1'b1;
      if (t > TO) begin
        v.lat = TO + 1; v.rbyte = 8'hFF; v.err = 1'b1;
      end else begin
        v.lat = t + 1;
        sh = v.rdata >> (8 * int'(v.a[1:0]));
        v.err = (v.rresp != 2'b00);
        v.rbyte = v.err ? 8'hFF : sh[7:0];
      end
    end else if (v.at == AT_AXI) begin
      t = ((v.awl > v.wl) ? v.awl : v.wl) + v.bl + 2;
      if (t > TO) begin
        v.lat = TO + 1; v.rbyte = 8'hFF;
        v.err = 1'b1; v.chkrd = 1'b1;
      end else begin
        v.lat = t + 1; v.err = (v.bresp != 2'b00);
      end
    end else if (is_int_t(v.at)) begin
      v.lat = v.rd ? 3 : 2;
      if (v.rd) begin
        v.rbyte = mem_exp(v.a[11:0]); v.chkrd = 1'b1;
      end
    end else begin
      v.lat = 1; v.rbyte = 8'hFF; v.err = 1'b1; v.chkrd = 1'b1;
    end
  endfunction

  task automatic run_cycle(input vec_t v, input string nm);
    int n, ar0, r0, aw0, w0, b0, is0, e0, tr, tw;
    logic held;
    logic [7:0] rb;
    ar0 = ar_hs; r0 = r_hs; aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    is0 = isel_n; e0 = err_n;
    arl_v = v.arl; rl_v = v.rl; awl_v = v.awl;
    wl_v = v.wl; bl_v = v.bl;
    rdata_v = v.rdata; rresp_v = v.rresp; bresp_v = v.bresp;
    @(posedge clk); #1;
    addr_type = v.at; A32 = v.a; D32 = v.d;
    wstrb = v.strb; is_read = v.rd;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (!cpu_ready) begin A32 = $urandom; D32 = $urandom; end
    end while (!cpu_ready && n < 40);
    chk({nm, ".lat"}, n, v.lat);
    chk({nm, ".err"}, bus_err, v.err);
    if (v.chkrd) chk({nm, ".rdata"}, cpu_rdata, v.rbyte);
    chk({nm, ".idle_vr"},
        {bus.m_arvalid, bus.m_rready, bus.m_awvalid,
         bus.m_wvalid, bus.m_bready}, 0);
    rb = cpu_rdata; held = 1'b1;
    repeat (3) begin
      A32 = $urandom; D32 = $urandom;
      @(posedge clk); #1;
      if (!cpu_ready || cpu_rdata !== rb) held = 1'b0;
    end
    chk({nm, ".held"}, held, 1'b1);
    addr_type = AT_NOP;
    @(posedge clk); #1;
    chk({nm, ".release"}, cpu_ready, 1'b0);
    @(posedge clk); #1;
    chk({nm, ".errpulses"}, err_n - e0, v.err ? 1 : 0);
    chk({nm, ".isel"}, isel_n - is0, is_int_t(v.at) ? 1 : 0);
    tr = v.arl + v.rl + 2;
    tw = ((v.awl > v.wl) ? v.awl : v.wl) + v.bl + 2;
    if (v.at == AT_AXI && v.rd) begin
      chk({nm, ".ar"}, ar_hs - ar0, (v.arl + 1 <= TO) ? 1 : 0);
      chk({nm, ".r"}, r_hs - r0, (tr <= TO) ? 1 : 0);
      chk({nm, ".wr_none"}, aw_hs - aw0 + w_hs - w0 + b_hs - b0, 0);
      if (v.arl + 1 <= TO) chk({nm, ".araddr"}, cap_araddr, v.a);
    end else if (v.at == AT_AXI) begin
      chk({nm, ".aw"}, aw_hs - aw0, (v.awl + 1 <= TO) ? 1 : 0);
      chk({nm, ".w"}, w_hs - w0, (v.wl + 1 <= TO) ? 1 : 0);
      chk({nm, ".b"}, b_hs - b0, (tw <= TO) ? 1 : 0);
      chk({nm, ".rd_none"}, ar_hs - ar0 + r_hs - r0, 0);
      if (v.awl + 1 <= TO) chk({nm, ".awaddr"}, cap_awaddr, v.a);
      if (v.wl + 1 <= TO) begin
        chk({nm, ".wdata"}, cap_wdata, v.d);
        chk({nm, ".wstrb"}, cap_wstrb, v.strb);
      end
    end else begin
      chk({nm, ".axi_none"},
          ar_hs - ar0 + r_hs - r0 + aw_hs - aw0 +
          w_hs - w0 + b_hs - b0, 0);
      if (is_int_t(v.at)) begin
        chk({nm, ".iaddr"}, cap_iaddr, v.a[11:0]);
        chk({nm, ".itype"}, cap_itype, v.at);
        chk({nm, ".iwe"}, cap_iwe, !v.rd);
        if (!v.rd) chk({nm, ".iwdata"}, cap_iwdata, v.d[7:0]);
      end
    end
  endtask

  vec_t tab [13];
  vec_t rv;

  initial begin
    tab[0]  = mk(AT_AXI, 32'h1000_0000, 0, 4'hF, 1, 0, 0, 0, 0, 0,
                 32'h1122_3344, 0, 0, 3, 8'h44, 0, 1);
    tab[1]  = mk(AT_AXI, 32'h2000_0002, 0, 4'hF, 1, 0, 3, 0, 0, 0,
                 32'hAABB_CCDD, 0, 0, 6, 8'hBB, 0, 1);
    tab[2]  = mk(AT_AXI, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 3, 8'h00, 0, 0);
    tab[3]  = mk(AT_AXI, 32'h3000_0020, 32'h5A5A_5A5A, 4'b1000, 0,
                 0, 0, 0, 2, 0, 0, 0, 0, 5, 8'h00, 0, 0);
    tab[4]  = mk(AT_RAM, 32'h0000_0123, 32'h0000_0042, 4'hF, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 2, 8'h00, 0, 0);
    tab[5]  = mk(AT_RAM, 32'h0000_0123, 0, 4'hF, 1,
                 0, 0, 0, 0, 0, 0, 0, 0, 3, 8'h42, 0, 1);
    tab[6]  = mk(AT_AXI, 32'h5000_0001, 0, 4'hF, 1, 0, 0, 0, 0, 0,
                 32'h1234_5678, 2'b10, 0, 3, 8'hFF, 1, 1);
    tab[7]  = mk(AT_UNK, 32'h4000_0000, 32'h1234, 4'hF, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'hFF, 1, 1);
    tab[8]  = mk(AT_AXI, 32'h6000_0004, 32'h0BAD_F00D, 4'h3, 0,
                 0, 0, 1, 0, 0, 0, 0, 2'b10, 4, 8'h00, 1, 0);
    tab[9]  = mk(AT_AXI, 32'h7000_0000, 0, 4'hF, 1, 200, 0, 0, 0, 0,
                 0, 0, 0, 9, 8'hFF, 1, 1);
    tab[10] = mk(AT_AXI, 32'h7000_0008, 32'h0102_0304, 4'hF, 0,
                 0, 0, 0, 0, 200, 0, 0, 0, 9, 8'hFF, 1, 1);
    tab[11] = mk(AT_AXI, 32'h8000_0003, 0, 4'hF, 1, 1, 1, 0, 0, 0,
                 32'hAABB_CCDD, 0, 0, 5, 8'hAA, 0, 1);
    tab[12] = mk(AT_ROM, 32'h0000_07F0, 0, 4'hF, 1,
                 0, 0, 0, 0, 0, 0, 0, 0, 3, 8'h55, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst.cpu_ready", cpu_ready, 0);
    chk("rst.cpu_rdata", cpu_rdata, 0);
    chk("rst.int", {int_sel, int_type, int_addr, int_wdata, int_we}, 0);
    chk("rst.bus_err", bus_err, 0);
    chk("rst.vr", {bus.m_arvalid, bus.m_rready, bus.m_awvalid,
                   bus.m_wvalid, bus.m_bready}, 0);
    chk("rst.araddr", bus.m_araddr, 0);
    chk("rst.awaddr", bus.m_awaddr, 0);
    chk("rst.wdata", {bus.m_wdata[27:0], bus.m_wstrb}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      run_cycle(tab[i], $sformatf("tab%0d", i));

    // reset while waiting for the write response
    arl_v = 0; rl_v = 0; awl_v = 0; wl_v = 0; bl_v = 200;
    bresp_v = 0;
    @(posedge clk); #1;
    addr_type = AT_AXI; A32 = 32'h9000_0000; D32 = 32'hCAFE_F00D;
    wstrb = 4'hF; is_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstB.in_b", bus.m_bready, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstB.bready", bus.m_bready, 0);
    chk("rstB.cpu", {cpu_ready, cpu_rdata, bus_err}, 0);
    chk("rstB.awaddr", bus.m_awaddr, 0);
    chk("rstB.wdata", bus.m_wdata, 0);
    chk("rstB.wstrb", bus.m_wstrb, 0);
    addr_type = AT_NOP;
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle(tab[1], "after_rst");

    for (int i = 0; i < 80; i++) begin
      int k;
      k = $urandom_range(0, 5);
      rv.at = (k <= 1) ? AT_AXI : (k == 2) ? AT_ROM :
              (k == 3) ? AT_RAM : (k == 4) ? AT_PER : AT_UNK;
      rv.a = $urandom; rv.d = $urandom;
      rv.strb = 4'($urandom); rv.rd = 1'($urandom);
      rv.arl = ($urandom_range(0, 9) == 0) ? 200 : $urandom_range(0, 3);
      rv.rl  = $urandom_range(0, 3);
      rv.awl = $urandom_range(0, 3);
      rv.wl  = $urandom_range(0, 3);
      rv.bl  = ($urandom_range(0, 9) == 0) ? 200 : $urandom_range(0, 3);
      rv.rdata = $urandom;
      rv.rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      rv.bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      model(rv);
      run_cycle(rv, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
